// File: rtl/bram_access_master.sv
// Load/store initiator for one byte-enabled block RAM port.
// Misaligned accesses that cross a word boundary are issued as two beats.
module bram_access_master #(
  parameter int ADDRESS_BITWIDTH     = 16,
  parameter int DATA_BITWIDTH        = 32,
  parameter int DATA_COLUMN_BITWIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [ADDRESS_BITWIDTH+1:0]   req_address,
  input  logic [DATA_BITWIDTH-1:0]      req_data,
  output logic                          rsp_valid,
  output logic [DATA_BITWIDTH-1:0]      rsp_data,
  output logic                          rsp_error,
  output logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0] ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0]   ram_address,
  output logic [DATA_BITWIDTH-1:0]      ram_data_out,
  input  logic [DATA_BITWIDTH-1:0]      ram_data_in
);

  localparam int A = ADDRESS_BITWIDTH;
  localparam int D = DATA_BITWIDTH;
  localparam int C = DATA_COLUMN_BITWIDTH;
  localparam int L = D / C;

  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    FIN
  } state_t;

  state_t         state;
  logic [1:0]     off_q;
  logic [1:0]     size_q;
  logic           sign_q;
  logic           write_q;
  logic           split_q;
  logic [L-1:0]   we1_q;
  logic [D-1:0]   data1_q;
  logic [D-1:0]   word0_q;

  logic [1:0]     off;
  logic [L-1:0]   size_mask;
  logic [2*L-1:0] lane_mask;
  logic [2*D-1:0] wide_data;
  logic           is_split;

  logic [2*D-1:0] both;
  logic [D-1:0]   raw;
  logic [D-1:0]   load_val;

  assign off       = req_address[1:0];
  assign req_ready = rst_n && (state == IDLE);

  // Lanes and data spread over a two-word window; upper half is beat1.
  always_comb begin
    size_mask = '1;
    unique case (req_size)
      2'd0:    size_mask = L'(1);
      2'd1:    size_mask = L'(3);
      default: size_mask = '1;
    endcase
    lane_mask = {{L{1'b0}}, size_mask} << off;
    wide_data = {{D{1'b0}}, req_data} << (C * int'(off));
    is_split  = |lane_mask[2*L-1:L];
  end

  always_comb begin
    both = split_q ? {ram_data_in, word0_q}
                   : {{D{1'b0}}, ram_data_in};
    raw  = D'(both >> (C * int'(off_q)));
    load_val = raw;
    unique case (size_q)
      2'd0: load_val = {{(D-C){sign_q & raw[C-1]}},
                        raw[C-1:0]};
      2'd1: load_val = {{(D-2*C){sign_q & raw[2*C-1]}},
                        raw[2*C-1:0]};
      default: load_val = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      rsp_valid        <= 1'b0;
      rsp_error        <= 1'b0;
      rsp_data         <= '0;
      ram_write_enable <= '0;
      ram_address      <= '0;
      ram_data_out     <= '0;
      off_q            <= '0;
      size_q           <= '0;
      sign_q           <= 1'b0;
      write_q          <= 1'b0;
      split_q          <= 1'b0;
      we1_q            <= '0;
      data1_q          <= '0;
      word0_q          <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_size == 2'd3) begin
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_data  <= '0;
            end else begin
              ram_address      <= req_address[A+1:2];
              ram_write_enable <= req_write ? lane_mask[L-1:0] : '0;
              ram_data_out     <= req_write ? wide_data[D-1:0] : '0;
              we1_q            <= req_write ? lane_mask[2*L-1:L] : '0;
              data1_q          <= req_write ? wide_data[2*D-1:D] : '0;
              off_q            <= off;
              size_q           <= req_size;
              sign_q           <= req_signed;
              write_q          <= req_write;
              split_q          <= is_split;
              state            <= B0;
            end
          end
        end
        B0: begin
          if (split_q) begin
            ram_address      <= ram_address + 1'b1;
            ram_write_enable <= we1_q;
            ram_data_out     <= data1_q;
            state            <= B1;
          end else begin
            ram_write_enable <= '0;
            state            <= FIN;
          end
        end
        B1: begin
          ram_write_enable <= '0;
          word0_q          <= ram_data_in;
          state            <= FIN;
        end
        FIN: begin
          rsp_valid <= 1'b1;
          rsp_data  <= write_q ? '0 : load_val;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_access_master.sv
// Bench for bram_access_master: fixed vectors, corner sequences and
// random traffic checked against a byte-level memory model.
module tb_bram_access_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [17:0] req_address;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [3:0]  ram_write_enable;
  logic [15:0] ram_address;
  logic [31:0] ram_data_out;
  logic [31:0] ram_data_in;

  int total = 0;
  int bad   = 0;

  bit [31:0] ram  [0:65535];
  bit [7:0]  rmem [0:262143];

  logic [15:0] bq_addr [0:3];
  logic [3:0]  bq_we   [0:3];
  logic [31:0] bq_data [0:3];

  bram_access_master dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_address      (req_address),
    .req_data         (req_data),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_data_in      (ram_data_in)
  );

  always #5 clk = ~clk;

  // Byte-enabled RAM, read-first, one cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_write_enable[i])
        ram[ram_address][8*i+:8] <= ram_data_out[8*i+:8];
    ram_data_in <= ram[ram_address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(bit [1:0] sz, bit sg,
                                           bit [17:0] a);
    int n = 1 << sz;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v[8*i+:8] = rmem[(int'(a) + i) & 32'h3FFFF];
    if (sg && n < 4 && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(bit [1:0] sz, bit [17:0] a, bit [31:0] d);
    int n = 1 << sz;
    for (int i = 0; i < n; i++)
      rmem[(int'(a) + i) & 32'h3FFFF] = d[8*i+:8];
  endtask

  function automatic int ref_lat(bit [1:0] sz, bit [17:0] a);
    if (sz == 2'd3) return 1;
    return (int'(a[1:0]) + (1 << sz) > 4) ? 4 : 3;
  endfunction

  // Caller is at a falling edge; returns at the rsp falling edge.
  task automatic do_req(input bit w, input bit [1:0] sz, input bit sg,
                        input bit [17:0] a, input bit [31:0] d,
                        output logic [31:0] rd, output logic re,
                        output int lat, output int nwe);
    int n = 0;
    req_write   = w;
    req_size    = sz;
    req_signed  = sg;
    req_address = a;
    req_data    = d;
    req_valid   = 1'b1;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    req_write   = 1'($urandom);
    req_size    = 2'($urandom);
    req_signed  = 1'($urandom);
    req_address = 18'($urandom);
    req_data    = $urandom;
    lat = -1;
    nwe = 0;
    rd  = '0;
    re  = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        bq_addr[c] = ram_address;
        bq_we[c]   = ram_write_enable;
        bq_data[c] = ram_data_out;
      end
      if (|ram_write_enable) nwe++;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_data;
        re  = rsp_error;
        break;
      end
    end
    if (w && sz != 2'd3 && lat > 0) ref_store(sz, a, d);
  endtask

  task automatic run_ref(input string nm, input bit w, input bit [1:0] sz,
                         input bit sg, input bit [17:0] a,
                         input bit [31:0] d);
    logic [31:0] xd, rd;
    logic        re;
    int          lat, nwe;
    xd = (w || sz == 2'd3) ? 32'h0 : ref_load(sz, sg, a);
    do_req(w, sz, sg, a, d, rd, re, lat, nwe);
    chk({nm, " data"}, rd, xd);
    chk({nm, " err"}, 32'(re), 32'(sz == 2'd3));
    chk({nm, " lat"}, lat, ref_lat(sz, a));
  endtask

  typedef struct {
    bit        w;
    bit [1:0]  sz;
    bit        sg;
    bit [17:0] a;
    bit [31:0] d;
    bit [31:0] xd;
    bit        xe;
    int        xl;
    int        xn;
  } vec_t;

  initial begin
    vec_t        tv[$];
    logic [31:0] rd;
    logic        re;
    int          lat, nwe, prev, pulses;
    bit          w, sg;
    bit [1:0]    sz;
    bit [17:0]   a;

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_size    = 2'd0;
    req_signed  = 1'b0;
    req_address = '0;
    req_data    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_data", rsp_data, 0);
    chk("rst rsp_error", 32'(rsp_error), 0);
    chk("rst we", 32'(ram_write_enable), 0);
    chk("rst addr", 32'(ram_address), 0);
    chk("rst dout", ram_data_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle ready", 32'(req_ready), 1);
    chk("idle rsp_valid", 32'(rsp_valid), 0);

    do_req(1, 2, 0, 18'h00010, 32'hDEADBEEF, rd, re, lat, nwe);
    chk("sw addr", 32'(bq_addr[1]), 32'h4);
    chk("sw we", 32'(bq_we[1]), 32'hF);
    chk("sw dout", bq_data[1], 32'hDEADBEEF);
    chk("sw lat", lat, 3);
    chk("sw nwe", nwe, 1);
    chk("sw rsp", rd, 0);

    do_req(1, 0, 0, 18'h00013, 32'h000000A5, rd, re, lat, nwe);
    chk("sb we", 32'(bq_we[1]), 32'h8);
    chk("sb dout", bq_data[1], 32'hA5000000);

    do_req(1, 2, 0, 18'h00006, 32'h11223344, rd, re, lat, nwe);
    chk("split b0 addr", 32'(bq_addr[1]), 32'h1);
    chk("split b0 we", 32'(bq_we[1]), 32'hC);
    chk("split b0 dout", bq_data[1], 32'h33440000);
    chk("split b1 addr", 32'(bq_addr[2]), 32'h2);
    chk("split b1 we", 32'(bq_we[2]), 32'h3);
    chk("split b1 dout", bq_data[2], 32'h00001122);
    chk("split lat", lat, 4);
    chk("split nwe", nwe, 2);

    do_req(1, 2, 0, 18'h3FFFE, 32'hCAFEF00D, rd, re, lat, nwe);
    chk("wrap b0 addr", 32'(bq_addr[1]), 32'hFFFF);
    chk("wrap b1 addr", 32'(bq_addr[2]), 32'h0);
    chk("wrap b1 we", 32'(bq_we[2]), 32'h3);

    tv.push_back('{0, 2, 0, 18'h00010, 0, 32'hA5ADBEEF, 0, 3, 0});
    tv.push_back('{0, 0, 1, 18'h00013, 0, 32'hFFFFFFA5, 0, 3, 0});
    tv.push_back('{0, 0, 0, 18'h00013, 0, 32'h000000A5, 0, 3, 0});
    tv.push_back('{0, 2, 0, 18'h00006, 0, 32'h11223344, 0, 4, 0});
    tv.push_back('{0, 2, 1, 18'h3FFFE, 0, 32'hCAFEF00D, 0, 4, 0});
    tv.push_back('{0, 1, 0, 18'h00000, 0, 32'h0000CAFE, 0, 3, 0});
    tv.push_back('{1, 0, 0, 18'h00003, 32'h80, 0, 0, 3, 1});
    tv.push_back('{1, 0, 0, 18'h00004, 32'hFF, 0, 0, 3, 1});
    tv.push_back('{0, 1, 1, 18'h00003, 0, 32'hFFFFFF80, 0, 4, 0});
    tv.push_back('{0, 1, 0, 18'h00003, 0, 32'h0000FF80, 0, 4, 0});
    tv.push_back('{0, 1, 1, 18'h00001, 0, 32'h000000CA, 0, 3, 0});
    tv.push_back('{0, 3, 0, 18'h00020, 0, 0, 1, 1, 0});
    tv.push_back('{1, 3, 0, 18'h00020, 32'hFFFFFFFF, 0, 1, 1, 0});
    tv.push_back('{0, 2, 0, 18'h00020, 0, 0, 0, 3, 0});
    tv.push_back('{1, 1, 0, 18'h00023, 32'h0000BEEF, 0, 0, 4, 2});
    tv.push_back('{0, 1, 0, 18'h00023, 0, 32'h0000BEEF, 0, 4, 0});

    foreach (tv[i]) begin
      do_req(tv[i].w, tv[i].sz, tv[i].sg, tv[i].a, tv[i].d,
             rd, re, lat, nwe);
      chk($sformatf("vec%0d data", i), rd, tv[i].xd);
      chk($sformatf("vec%0d err", i), 32'(re), 32'(tv[i].xe));
      chk($sformatf("vec%0d lat", i), lat, tv[i].xl);
      chk($sformatf("vec%0d nwe", i), nwe, tv[i].xn);
    end

    // Request held valid: a new accept on every rsp_valid cycle.
    req_write   = 1'b0;
    req_size    = 2'd2;
    req_signed  = 1'b0;
    req_address = 18'h00010;
    req_valid   = 1'b1;
    prev   = -1;
    pulses = 0;
    for (int cy = 0; cy < 30; cy++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("b2b data", rsp_data, 32'hA5ADBEEF);
        chk("b2b ready", 32'(req_ready), 1);
        if (prev >= 0) chk("b2b gap", cy - prev, 3);
        prev = cy;
        pulses++;
      end
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("b2b pulses", pulses, 10);

    // Reset during beat0 of a split store drops beat1 and the response.
    req_write   = 1'b1;
    req_size    = 2'd2;
    req_address = 18'h00106;
    req_data    = 32'h55667788;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort b0 we", 32'(ram_write_enable), 32'hC);
    chk("abort b0 addr", 32'(ram_address), 32'h41);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort we", 32'(ram_write_enable), 0);
    chk("abort rsp", 32'(rsp_valid), 0);
    chk("abort ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post abort we", 32'(ram_write_enable), 0);
      chk("post abort rsp", 32'(rsp_valid), 0);
    end
    rmem[18'h106] = 8'h88;
    rmem[18'h107] = 8'h77;
    run_ref("abort lo", 0, 2, 0, 18'h00104, 0);
    run_ref("abort hi", 0, 2, 0, 18'h00108, 0);

    for (int i = 0; i < 300; i++) begin
      w  = 1'($urandom);
      sg = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3
                                         : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        a = 18'h3FFC0 + 18'($urandom_range(0, 63));
      else
        a = 18'($urandom_range(0, 63));
      run_ref($sformatf("rnd%0d", i), w, sz, sg, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
